// File: rtl/spi_v3_pkg.sv
// Shared definitions for the SPI v3 clock-controlled slave/master block.
//   - word width and divider counter width
//   - transfer state enum (IDLE, TRANSFER, DONE)
//   - freq_control -> CLK_DIV lookup
package spi_v3_pkg;

  localparam int WORD_W = 16;
  localparam int DIV_W  = 5;
  localparam int CNT_W  = 5;   // holds 0..WORD_W

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    DONE     = 2'd2
  } state_t;

  // sclk half-period is CLK_DIV+1 clk cycles.
  function automatic logic [DIV_W-1:0] clk_div_of(input logic [1:0] fc);
    logic [DIV_W-1:0] d;
    case (fc)
      2'b00:   d = DIV_W'(4);
      2'b01:   d = DIV_W'(0);
      2'b10:   d = DIV_W'(12);
      default: d = DIV_W'(24);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// sclk divider / generator.
//   clk, reset : system clock, async active-high reset
//   enable     : run sclk; when low sclk and divider are held at 0
//   clk_div    : sclk toggles every clk_div+1 clk cycles
//   sclk       : serial clock, idle low
//   rise, fall : strobes, high in the cycle whose clk edge toggles sclk 0->1 / 1->0
module spi_sclk_gen
  import spi_v3_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             sclk,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] cnt;
  logic             tick;

  assign tick = enable && (cnt == clk_div);
  // Strobes describe the toggle that the coming edge performs.
  assign rise = tick & ~sclk;
  assign fall = tick &  sclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_slave_v3_clk_ctrl.sv
// SPI v3 transfer engine, mode 0, MSB first, 16-bit words.
//   clk, reset               : system clock, async active-high reset
//   slave_tx_start/rx_start  : one-clk start pulses (both -> full duplex)
//   loopback                 : TX source at start: 1 = rx_word, 0 = tx_word
//   mosi                     : serial input, sampled on sclk rise
//   freq_control             : sclk rate select, latched at start
//   cs_bar                   : start accepted only while high
//   sclk, miso               : serial clock / data out
//   rx_valid, tx_done        : completion levels, cleared by next start
module spi_master_slave_v3_clk_ctrl
  import spi_v3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       slave_tx_start,
  input  logic       slave_rx_start,
  input  logic       loopback,
  input  logic       mosi,
  input  logic [1:0] freq_control,
  input  logic       cs_bar,
  output logic       sclk,
  output logic       miso,
  output logic       rx_valid,
  output logic       tx_done
);

  state_t              state_q, state_d;
  logic                tx_en, rx_en;
  logic [DIV_W-1:0]    clk_div_q;
  logic [WORD_W-1:0]   tx_sh, rx_sh, tx_word, rx_word;
  logic [CNT_W-1:0]    bit_cnt;
  logic                start_ok, run, rise, fall, last_fall;

  assign start_ok  = (state_q == IDLE) && (slave_tx_start || slave_rx_start) && cs_bar;
  assign run       = (state_q == TRANSFER);
  // bit_cnt counts rises; the fall after the 16th rise closes the transfer.
  assign last_fall = fall && (bit_cnt == CNT_W'(WORD_W));
  assign miso      = run & tx_en & tx_sh[WORD_W-1];

  spi_sclk_gen u_sclk_gen (
    .clk     (clk),
    .reset   (reset),
    .enable  (run),
    .clk_div (clk_div_q),
    .sclk    (sclk),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok)  state_d = TRANSFER;
      TRANSFER: if (last_fall) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_en     <= 1'b0;
      rx_en     <= 1'b0;
      clk_div_q <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      tx_word   <= 16'h55AA;
      rx_word   <= '0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
    end else if (start_ok) begin
      tx_en     <= slave_tx_start;
      rx_en     <= slave_rx_start;
      clk_div_q <= clk_div_of(freq_control);
      tx_sh     <= loopback ? rx_word : tx_word;
      bit_cnt   <= '0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
    end else if (run) begin
      if (rise) begin
        rx_sh   <= {rx_sh[WORD_W-2:0], mosi};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall)
        tx_sh <= {tx_sh[WORD_W-2:0], 1'b0};
      if (last_fall) begin
        tx_done  <= tx_en;
        rx_valid <= rx_en;
        // Received word also becomes the next TX word.
        if (rx_en) begin
          rx_word <= rx_sh;
          tx_word <= rx_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_slave_v3_clk_ctrl.sv
module tb_spi_master_slave_v3_clk_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slave_tx_start = 1'b0, slave_rx_start = 1'b0, loopback = 1'b0, mosi = 1'b0;
  logic [1:0] freq_control = 2'b01;
  logic       cs_bar = 1'b1;
  logic       sclk, miso, rx_valid, tx_done;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [15:0] m_tx = 16'h55AA;
  logic [15:0] m_rx = 16'h0000;

  spi_master_slave_v3_clk_ctrl dut (
    .clk(clk), .reset(reset), .slave_tx_start(slave_tx_start), .slave_rx_start(slave_rx_start),
    .loopback(loopback), .mosi(mosi), .freq_control(freq_control), .cs_bar(cs_bar),
    .sclk(sclk), .miso(miso), .rx_valid(rx_valid), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] fc);
    case (fc)
      2'b00: return 4;
      2'b01: return 0;
      2'b10: return 12;
      default: return 24;
    endcase
  endfunction

  // One transfer: drive start, play mosi, capture miso at sclk rise, measure timing.
  task automatic xfer(input logic tx, input logic rx, input logic lb, input logic [1:0] fc,
                      input logic [15:0] mw, input logic poke);
    int d, k, nr, lastt, hmin, hmax, done_k, lim;
    logic prev;
    logic [15:0] got, exp_send;
    d = div_of(fc);
    exp_send = tx ? (lb ? m_rx : m_tx) : 16'h0000;
    @(negedge clk);
    slave_tx_start = tx; slave_rx_start = rx; loopback = lb; freq_control = fc; mosi = mw[15];
    @(negedge clk);
    slave_tx_start = 1'b0; slave_rx_start = 1'b0;
    loopback = 1'($urandom); freq_control = 2'($urandom);
    chk("flags_clr_tx", {31'd0, tx_done}, 32'd0);
    chk("flags_clr_rx", {31'd0, rx_valid}, 32'd0);
    k = 0; nr = 0; lastt = 0; hmin = 1000000; hmax = 0; done_k = -1; prev = 1'b0; got = '0;
    lim = 32 * (d + 1) + 40;
    while (done_k < 0 && k < lim) begin
      @(negedge clk);
      k++;
      if (poke) begin
        slave_tx_start = (k == 5); slave_rx_start = (k == 5);
      end
      if (sclk !== prev) begin
        if (k - lastt < hmin) hmin = k - lastt;
        if (k - lastt > hmax) hmax = k - lastt;
        lastt = k;
        if (sclk) begin
          got = {got[14:0], miso};
          nr++;
        end
        prev = sclk;
      end
      if (!sclk && nr < 16) mosi = mw[15 - nr];
      if (tx_done || rx_valid) done_k = k;
    end
    slave_tx_start = 1'b0; slave_rx_start = 1'b0;
    chk("duration", done_k, 32 * (d + 1));
    chk("tx_done", {31'd0, tx_done}, {31'd0, tx});
    chk("rx_valid", {31'd0, rx_valid}, {31'd0, rx});
    chk("miso_word", {16'd0, got}, {16'd0, exp_send});
    chk("rise_count", nr, 16);
    chk("half_min", hmin, d + 1);
    chk("half_max", hmax, d + 1);
    chk("sclk_idle", {31'd0, sclk}, 32'd0);
    repeat (3) @(negedge clk);
    chk("flags_hold", {30'd0, tx_done, rx_valid}, {30'd0, tx, rx});
    if (rx) begin
      m_rx = mw;
      m_tx = mw;
    end
  endtask

  initial begin
    #12;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // TX only, fastest clock
    xfer(1, 0, 0, 2'b01, 16'h0000, 0);
    // RX only, then loopback TX of received word
    xfer(0, 1, 0, 2'b01, 16'hA55A, 0);
    xfer(1, 0, 1, 2'b01, 16'h0000, 0);
    // full duplex with loopback, then loopback TX of new word
    xfer(1, 1, 1, 2'b01, 16'h5678, 0);
    xfer(1, 0, 1, 2'b01, 16'h0000, 0);
    // slowest clock
    xfer(1, 0, 0, 2'b11, 16'h0000, 0);
    // start pulses during transfer are ignored
    xfer(1, 1, 0, 2'b00, 16'hC3E1, 1);

    // start with cs_bar low is ignored
    begin
      logic sc_hi;
      logic [1:0] fl;
      fl = {tx_done, rx_valid};
      sc_hi = 1'b0;
      @(negedge clk); cs_bar = 1'b0; slave_tx_start = 1'b1; slave_rx_start = 1'b1;
      @(negedge clk); slave_tx_start = 1'b0; slave_rx_start = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (sclk) sc_hi = 1'b1;
      end
      cs_bar = 1'b1;
      chk("csbar_sclk", {31'd0, sc_hi}, 32'd0);
      chk("csbar_flags", {30'd0, tx_done, rx_valid}, {30'd0, fl});
    end

    // reset in the middle of a transfer
    @(negedge clk); slave_tx_start = 1'b1; slave_rx_start = 1'b1; freq_control = 2'b00;
    @(negedge clk); slave_tx_start = 1'b0; slave_rx_start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_sclk", {31'd0, sclk}, 32'd0);
    chk("midrst_miso", {31'd0, miso}, 32'd0);
    chk("midrst_flags", {30'd0, tx_done, rx_valid}, 32'd0);
    m_tx = 16'h55AA; m_rx = 16'h0000;
    @(posedge clk); #1 reset = 1'b0;
    xfer(1, 0, 0, 2'b10, 16'h0000, 0);

    // randomized transfers
    for (int i = 0; i < 12; i++) begin
      logic t, r;
      t = 1'($urandom);
      r = 1'($urandom);
      if (!t && !r) t = 1'b1;
      xfer(t, r, 1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
